// File: rtl/audio_sample_fifo.sv
// Stereo frame FIFO between the WM8731 deserializer and the DSP stage.
// First-word-fall-through output; when full, incoming frames are dropped and a sticky flag is set.
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

module audio_sample_fifo #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                        xclk_i,
  input  logic                        rst_ni,
  input  logic [DATA_WIDTH-1:0]       left_i,
  input  logic [DATA_WIDTH-1:0]       right_i,
  input  logic                        valid_i,
  output logic [DATA_WIDTH-1:0]       left_o,
  output logic [DATA_WIDTH-1:0]       right_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        almost_full_o,
  output logic                        overflow_o,
  input  logic                        clr_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = 2 * DATA_WIDTH;

  logic [FW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic          empty, full, push, pop, drop;
  logic [FW-1:0] head;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop      = !empty && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
    push     = valid_i && (!full || pop);
    drop     = valid_i && !push;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + PW'(1);
    end else if (pop && !push) begin
      level_d = level_q - PW'(1);
    end
    afull_d = (level_d >= PW'(AFULL_LEVEL));
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge xclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge xclk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {left_i, right_i};
    end
  end

  always_comb begin
    head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    left_o  = head[FW-1:DATA_WIDTH];
    right_o = head[DATA_WIDTH-1:0];
  end

  assign valid_o       = !empty;
  assign level_o       = level_q;
  assign almost_full_o = afull_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: directed and random stimulus checked against a queue model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

module tb_audio_sample_fifo;

  localparam int DW    = `DATA_WIDTH;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] left_i = '0, right_i = '0;
  logic          valid_i = 1'b0, ready_i = 1'b0, clr_ovf_i = 1'b0;
  logic [DW-1:0] left_o, right_o;
  logic          valid_o, almost_full_o, overflow_o;
  logic [PW-1:0] level_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [2*DW-1:0] mq[$];
  logic            m_ovf = 1'b0;

  always #5 clk = ~clk;

  audio_sample_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .xclk_i       (clk),
    .rst_ni       (rst_n),
    .left_i       (left_i),
    .right_i      (right_i),
    .valid_i      (valid_i),
    .left_o       (left_o),
    .right_o      (right_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .almost_full_o(almost_full_o),
    .overflow_o   (overflow_o),
    .clr_ovf_i    (clr_ovf_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [2*DW-1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("valid_o", 64'(valid_o), 64'(mq.size() != 0));
    check("left_o", 64'(left_o), 64'(h[2*DW-1:DW]));
    check("right_o", 64'(right_o), 64'(h[DW-1:0]));
    check("level_o", 64'(level_o), 64'(mq.size()));
    check("almost_full_o", 64'(almost_full_o), 64'(mq.size() >= AFULL));
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the reference model at the edge, then compare.
  task automatic cyc(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                     input logic rdy, input logic clr);
    bit do_pop, do_push;
    valid_i = v; left_i = l; right_i = r; ready_i = rdy; clr_ovf_i = clr;
    @(posedge clk);
    do_pop  = (mq.size() > 0) && rdy;
    do_push = v && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({l, r});
    if (v && !do_push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_all();
  endtask

  task automatic fill_full(input int unsigned base);
    for (int unsigned k = 1; k <= DEPTH; k++)
      cyc(1'b1, DW'(base + k), DW'(-(base + k)), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < DEPTH; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_level", 64'(level_o), 64'd0);
    rst_n = 1'b1;

    // 1: single frame, one-cycle latency, then pop
    cyc(1'b1, DW'(24'h000123), DW'(24'hFFFEDC), 1'b0, 1'b0);
    check("t1_left", 64'(left_o), 64'(DW'(24'h000123)));
    check("t1_right", 64'(right_o), 64'(DW'(24'hFFFEDC)));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_empty", 64'(valid_o), 64'd0);

    // 2: fill to DEPTH
    fill_full(0);
    check("t2_level", 64'(level_o), 64'(DEPTH));

    // 3: drop while full, then drain in order
    cyc(1'b1, DW'(99), DW'(99), 1'b0, 1'b0);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    drain();
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // 4: simultaneous push and pop when full
    fill_full(100);
    cyc(1'b1, DW'(24'h000777), DW'(24'h000888), 1'b1, 1'b0);
    check("t4_level", 64'(level_o), 64'(DEPTH));
    check("t4_ovf", 64'(overflow_o), 64'd0);
    drain();

    // 5: drop and clear together -> set wins; clear alone next cycle
    fill_full(200);
    cyc(1'b1, DW'(5), DW'(5), 1'b0, 1'b1);
    check("t5_set_wins", 64'(overflow_o), 64'd1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check("t5_cleared", 64'(overflow_o), 64'd0);
    drain();

    // 6: streaming with async reset in the middle
    for (int unsigned f = 0; f < 40; f++) begin
      if (f == 20) begin
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(valid_o), 64'd0);
        check("t6_rst_level", 64'(level_o), 64'd0);
        mq.delete();
        m_ovf = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
      check("t6_level_le1", 64'(level_o <= 1), 64'd1);
      for (int unsigned w = 0; w < 3; w++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check("t6_no_ovf", 64'(overflow_o), 64'd0);

    // Random traffic, biased toward filling so overflow and full cases recur
    for (int unsigned i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), DW'($urandom), DW'($urandom),
          1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)),
          1'($urandom_range(0, 99) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
